alu_addc_chain: RTL and testbench

Multi-word add-with-carry sequencer for the XM23 execute stage. It performs extended-precision additions: operand words arrive low-order first over a valid/ready stream, and the carry is chained internally from word to word. It is the additive counterpart of the SUBC path. It reports XM23 PSW flags for the complete chain on the last word, so microcode can do 32/48/64-bit ADDC without re-reading the carry from the PSW between words.

---
 rtl/alu_addc_chain.sv | 95 +++++++++
 tb/tb_alu_addc_chain.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addc_chain.sv
// Multi-word add-with-carry sequencer: words stream in low-order first, carry is
// chained internally, and XM23 PSW flags for the whole chain appear with the last word.
module alu_addc_chain #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             carry_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             out_last,
   output logic [15:0]      psw_out,
   output logic [15:0]      psw_msk,
   output logic             busy,
   output logic [7:0]       word_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_nxt;
   logic             carry_reg;
   logic             zacc;
   logic             first;
   logic             accept;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             z_nxt;
   logic             v_nxt;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_ready && in_valid;
   assign busy     = (state != IDLE);
   assign psw_msk  = (out_valid && out_last) ? 16'h0017 : 16'h0000;

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_reg};
   assign z_nxt = zacc && (sum == '0);
   assign v_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (accept && in_last) state_nxt = DRAIN;
         DRAIN:   if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_reg <= 1'b0;
         zacc      <= 1'b1;
         first     <= 1'b0;
         word_idx  <= 8'd0;
         result    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         psw_out   <= 16'h0000;
      end else begin
         if (state == IDLE && start) begin
            carry_reg <= carry_in;
            zacc      <= 1'b1;
            first     <= 1'b1;
            word_idx  <= 8'd0;
         end
         if (accept) begin
            result    <= sum;
            carry_reg <= cout;
            zacc      <= z_nxt;
            out_valid <= 1'b1;
            out_last  <= in_last;
            first     <= 1'b0;
            if (!first) word_idx <= word_idx + 8'd1;
            // intermediate words only carry the running C/Z; msk keeps them out of the PSW
            if (in_last) psw_out <= {11'b0, v_nxt, 1'b0, sum[WIDTH-1], z_nxt, cout};
            else         psw_out <= {14'b0, z_nxt, cout};
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_addc_chain.sv
// Scoreboard bench for alu_addc_chain: expected words come from whole-number
// arithmetic over the concatenated chain, checked by an independent monitor.
module tb_alu_addc_chain;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          carry_in = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready, out_valid, out_last, busy;
   logic [W-1:0]  result;
   logic [15:0]   psw_out, psw_msk;
   logic [7:0]    word_idx;

   alu_addc_chain #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .carry_in(carry_in),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .out_last(out_last), .psw_out(psw_out), .psw_msk(psw_msk),
      .busy(busy), .word_idx(word_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] res;
      logic        last;
      logic [15:0] psw;
      logic [7:0]  idx;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           bp_mode = 0;   // 0: always ready, 1: random, 2: hold off
   logic [15:0]  ca[0:3];
   logic [15:0]  cb[0:3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (bp_mode == 1)      out_ready = 1'($urandom_range(0, 1));
      else if (bp_mode == 2) out_ready = 1'b0;
      else                   out_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got result %h with empty scoreboard", result);
         end else begin
            mon_e = sb.pop_front();
            chk("result",   32'(result),   32'(mon_e.res));
            chk("out_last", 32'(out_last), 32'(mon_e.last));
            chk("psw_out",  32'(psw_out),  32'(mon_e.psw));
            chk("psw_msk",  32'(psw_msk),  mon_e.last ? 32'h17 : 32'h0);
            chk("word_idx", 32'(word_idx), 32'(mon_e.idx));
         end
      end
   end

   // Whole-chain reference: partial sums of the first k bits give each word's running C/Z.
   task automatic model(input int n, input logic cin);
      logic [64:0] av, bv, mask, part;
      int          k;
      logic        c, z, ng, v;
      exp_t        e;
      av = '0;
      bv = '0;
      for (int i = 0; i < n; i++) begin
         av[i*16 +: 16] = ca[i];
         bv[i*16 +: 16] = cb[i];
      end
      for (int i = 0; i < n; i++) begin
         k    = (i + 1) * 16;
         mask = (65'd1 << k) - 65'd1;
         part = (av & mask) + (bv & mask) + 65'(cin);
         c    = part[k];
         z    = ((part & mask) == 65'd0);
         e.res  = part[i*16 +: 16];
         e.idx  = 8'(i);
         e.last = (i == n - 1);
         if (e.last) begin
            ng    = part[k-1];
            v     = (av[k-1] == bv[k-1]) && (part[k-1] != av[k-1]);
            e.psw = {11'b0, v, 1'b0, ng, z, c};
         end else begin
            e.psw = {14'b0, z, c};
         end
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
      end
   endtask

   task automatic start_chain(input logic cin);
      wait_idle();
      start    = 1'b1;
      carry_in = cin;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic send_word(input logic [15:0] wa, input logic [15:0] wb, input logic last);
      int n = 0;
      a        = wa;
      b        = wb;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready %b after %0d cycles", in_ready, n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_chain(input int n, input logic cin);
      model(n, cin);
      start_chain(cin);
      for (int i = 0; i < n; i++) send_word(ca[i], cb[i], i == n - 1);
      wait_idle();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"},  32'(out_last),  32'd0);
      chk({tag, "_result"},    32'(result),    32'd0);
      chk({tag, "_psw_out"},   32'(psw_out),   32'd0);
      chk({tag, "_psw_msk"},   32'(psw_msk),   32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_word_idx"},  32'(word_idx),  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r0, p0;
      exp_t        e;
      #2;
      chk_reset_outputs("reset");
      #10;
      rst_n = 1'b1;

      // 32-bit add across the word boundary
      ca[0] = 16'hFFFF; cb[0] = 16'h0001; ca[1] = 16'h0001; cb[1] = 16'h0000;
      run_chain(2, 1'b0);
      // chain that sums to zero with carry out
      ca[0] = 16'hFFFF; cb[0] = 16'h0001; ca[1] = 16'hFFFF; cb[1] = 16'h0000;
      run_chain(2, 1'b0);
      // single word, signed overflow
      ca[0] = 16'h7FFF; cb[0] = 16'h0001;
      run_chain(1, 1'b0);
      ca[0] = 16'hFFFF; cb[0] = 16'h0000;
      run_chain(1, 1'b1);

      // backpressure on the first word, then accept+drain in one cycle
      ca[0] = 16'($urandom); cb[0] = 16'($urandom);
      ca[1] = 16'($urandom); cb[1] = 16'($urandom);
      model(2, 1'b1);
      start_chain(1'b1);
      bp_mode = 2;
      send_word(ca[0], cb[0], 1'b0);
      r0 = result;
      p0 = psw_out;
      a = ca[1]; b = cb[1]; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result",    32'(result),    32'(r0));
         chk("bp_psw",       32'(psw_out),   32'(p0));
      end
      bp_mode = 0;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_idle();

      // start/in_valid while draining are ignored
      ca[0] = 16'($urandom); cb[0] = 16'($urandom);
      model(1, 1'b0);
      start_chain(1'b0);
      bp_mode = 2;
      send_word(ca[0], cb[0], 1'b1);
      start = 1'b1; carry_in = 1'b1; in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("drain_in_ready",  32'(in_ready),  32'd0);
         chk("drain_busy",      32'(busy),      32'd1);
         chk("drain_out_valid", 32'(out_valid), 32'd1);
      end
      start = 1'b0; in_valid = 1'b0;
      bp_mode = 0;
      wait_idle();
      @(negedge clk);
      chk("drain_no_extra_word", 32'(out_valid), 32'd0);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);

      // asynchronous reset mid-chain
      ca[0] = 16'h1234; cb[0] = 16'h4321; ca[1] = 16'h0F0F; cb[1] = 16'hF0F0;
      model(2, 1'b1);
      start_chain(1'b1);
      send_word(ca[0], cb[0], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ca[0] = 16'h8000; cb[0] = 16'h8000;
      run_chain(1, 1'b0);

      // random chains under random backpressure
      bp_mode = 1;
      for (int t = 0; t < 40; t++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               ca[i] = 16'hFFFF; cb[i] = 16'h0000;
            end else begin
               ca[i] = 16'($urandom); cb[i] = 16'($urandom);
            end
         end
         if (t % 8 == 0) begin
            for (int i = 0; i < 4; i++) begin ca[i] = 16'h0; cb[i] = 16'h0; end
         end
         run_chain(n, 1'($urandom_range(0, 1)));
      end
      bp_mode = 0;

      // long zero chain so word_idx wraps past 255
      for (int i = 0; i < 258; i++) begin
         e.res  = 16'h0;
         e.last = (i == 257);
         e.psw  = 16'h0002;
         e.idx  = 8'(i % 256);
         sb.push_back(e);
      end
      start_chain(1'b0);
      for (int i = 0; i < 258; i++) send_word(16'h0, 16'h0, i == 257);
      wait_idle();

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
